// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: latches request edges, takes the highest-priority
// enabled channel at an instruction boundary, stalls two cycles, then vectors the PC.
module irq_ctrl #(
   parameter int                  N_IRQ      = 4,
   parameter int                  PC_WIDTH   = 10,
   parameter logic [PC_WIDTH-1:0] VEC_BASE   = 10'h3C0,
   parameter int                  VEC_STRIDE = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_IRQ-1:0]    irq,
   input  logic                ei,
   input  logic                di,
   input  logic                reti,
   input  logic                we_mask,
   input  logic [N_IRQ-1:0]    mask_in,
   input  logic [PC_WIDTH-1:0] pc_next,
   input  logic                z_in,
   input  logic                n_in,
   output logic                stall,
   output logic                push_pc,
   output logic [PC_WIDTH-1:0] ret_pc,
   output logic                load_vec,
   output logic [PC_WIDTH-1:0] vector,
   output logic                flags_restore,
   output logic                z_out,
   output logic                n_out,
   output logic                ie,
   output logic                active,
   output logic [N_IRQ-1:0]    pending,
   output logic [2:0]          irq_id
);

   // state | meaning
   // IDLE  | core runs; takes and reti are evaluated here
   // SAVE  | core stalled; return PC pushed onto the hardware stack
   // JUMP  | core stalled; PC mux forced to the channel vector
   typedef enum logic [1:0] {IDLE, SAVE, JUMP} state_t;

   state_t            state_q, state_d;
   logic [N_IRQ-1:0]  irq_q;
   logic [N_IRQ-1:0]  mask;
   logic [N_IRQ-1:0]  eligible;
   logic [N_IRQ-1:0]  clr;
   logic [2:0]        win;
   logic              take;

   // Descending scan so the lowest eligible index is the one left in win.
   always_comb begin
      eligible = pending & mask;
      win      = 3'd0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) win = 3'(i);
      end
      take = (state_q == IDLE) && ie && !di && (|eligible);
      clr  = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         clr[i] = take && (win == 3'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      stall         = 1'b0;
      push_pc       = 1'b0;
      load_vec      = 1'b0;
      flags_restore = 1'b0;
      case (state_q)
         IDLE: begin
            flags_restore = reti && active;
            if (take) state_d = SAVE;
         end
         SAVE: begin
            stall   = 1'b1;
            push_pc = 1'b1;
            state_d = JUMP;
         end
         JUMP: begin
            stall    = 1'b1;
            load_vec = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q   <= '0;
         pending <= '0;
         mask    <= '0;
         ie      <= 1'b0;
         active  <= 1'b0;
         ret_pc  <= '0;
         irq_id  <= 3'd0;
         z_out   <= 1'b0;
         n_out   <= 1'b0;
      end else begin
         irq_q   <= irq;
         // A fresh edge on the channel being taken re-arms it.
         pending <= (pending & ~clr) | (irq & ~irq_q);
         if (we_mask) mask <= mask_in;
         if (take) begin
            ret_pc <= pc_next;
            irq_id <= win;
            z_out  <= z_in;
            n_out  <= n_in;
            ie     <= 1'b0;
            active <= 1'b1;
         end else if (state_q == IDLE) begin
            if (reti) active <= 1'b0;
            if (di)               ie <= 1'b0;
            else if (ei || reti)  ie <= 1'b1;
         end
      end
   end

   assign vector = VEC_BASE + PC_WIDTH'(int'(irq_id) * VEC_STRIDE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic checked against
// a cycle-level reference model of the controller's rules.
module tb_irq_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] irq = '0;
   logic       ei = 1'b0, di = 1'b0, reti = 1'b0, we_mask = 1'b0;
   logic [3:0] mask_in = '0;
   logic [9:0] pc_next = '0;
   logic       z_in = 1'b0, n_in = 1'b0;
   logic       stall, push_pc, load_vec, flags_restore, z_out, n_out, ie, active;
   logic [9:0] ret_pc, vector;
   logic [3:0] pending;
   logic [2:0] irq_id;

   int total = 0;
   int bad = 0;

   // reference model state; m_left counts remaining stall cycles of an entry
   int m_pend = 0, m_mask = 0, m_ie = 0, m_act = 0, m_prev = 0;
   int m_ret = 0, m_id = 0, m_z = 0, m_n = 0, m_left = 0;

   always #5 clk = ~clk;

   irq_ctrl dut (
      .clk(clk), .reset(reset), .irq(irq), .ei(ei), .di(di), .reti(reti),
      .we_mask(we_mask), .mask_in(mask_in), .pc_next(pc_next), .z_in(z_in), .n_in(n_in),
      .stall(stall), .push_pc(push_pc), .ret_pc(ret_pc), .load_vec(load_vec),
      .vector(vector), .flags_restore(flags_restore), .z_out(z_out), .n_out(n_out),
      .ie(ie), .active(active), .pending(pending), .irq_id(irq_id)
   );

   function automatic void model_step();
      int edges, e, w;
      edges = int'(irq) & ~m_prev & 15;
      if (reset) begin
         m_pend = 0; m_mask = 0; m_ie = 0; m_act = 0; m_prev = 0;
         m_ret = 0; m_id = 0; m_z = 0; m_n = 0; m_left = 0;
      end else begin
         e = m_pend & m_mask;
         if (m_left == 0 && m_ie != 0 && !di && e != 0) begin
            w      = $clog2(e & -e);
            m_pend = (m_pend & ~(1 << w)) | edges;
            m_ret  = int'(pc_next);
            m_id   = w;
            m_z    = int'(z_in);
            m_n    = int'(n_in);
            m_ie   = 0;
            m_act  = 1;
            m_left = 2;
         end else begin
            m_pend = m_pend | edges;
            if (m_left > 0) m_left = m_left - 1;
            else begin
               if (reti) m_act = 0;
               if (di) m_ie = 0;
               else if (ei || reti) m_ie = 1;
            end
         end
         if (we_mask) m_mask = int'(mask_in);
         m_prev = int'(irq);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      total++;
      if ({stall, push_pc, load_vec, flags_restore, ie, active, pending, irq_id, ret_pc, z_out, n_out} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got stall=%b push=%b load=%b fr=%b ie=%b act=%b pend=%b id=%0d ret=%h z=%b n=%b want all 0",
                  stall, push_pc, load_vec, flags_restore, ie, active, pending, irq_id, ret_pc, z_out, n_out);
      end
   endtask

   task automatic test_basic();
      we_mask = 1'b1; mask_in = 4'hF; ei = 1'b1;
      tick();
      we_mask = 1'b0; ei = 1'b0;
      irq = 4'b0100; pc_next = 10'h020;
      tick();
      irq = 4'b0000;
      total++;
      if ({pending, stall} !== {4'b0100, 1'b0}) begin
         bad++; $display("FAIL basic_pending got pend=%b stall=%b want 0100/0", pending, stall);
      end
      tick();
      total++;
      if ({stall, push_pc, load_vec, ret_pc} !== {3'b110, 10'h020}) begin
         bad++; $display("FAIL basic_save got s/p/l=%b%b%b ret=%h want 110 020", stall, push_pc, load_vec, ret_pc);
      end
      tick();
      total++;
      if ({stall, push_pc, load_vec, vector} !== {3'b101, 10'h3D0}) begin
         bad++; $display("FAIL basic_jump got s/p/l=%b%b%b vec=%h want 101 3d0", stall, push_pc, load_vec, vector);
      end
      tick();
      total++;
      if ({stall, active, ie, pending} !== {3'b010, 4'b0000}) begin
         bad++; $display("FAIL basic_after got stall=%b act=%b ie=%b pend=%b want 0 1 0 0000", stall, active, ie, pending);
      end
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   task automatic test_priority();
      irq = 4'b1010;
      tick();
      irq = 4'b0000;
      tick();
      total++;
      if ({push_pc, irq_id} !== {1'b1, 3'd1}) begin
         bad++; $display("FAIL prio_first got push=%b id=%0d want 1 1", push_pc, irq_id);
      end
      tick();
      total++;
      if ({load_vec, vector} !== {1'b1, 10'h3C8}) begin
         bad++; $display("FAIL prio_vec1 got load=%b vec=%h want 1 3c8", load_vec, vector);
      end
      tick();
      total++;
      if ({pending, active} !== {4'b1000, 1'b1}) begin
         bad++; $display("FAIL prio_left got pend=%b act=%b want 1000 1", pending, active);
      end
      reti = 1'b1;
      #1;
      total++;
      if (flags_restore !== 1'b1) begin
         bad++; $display("FAIL prio_restore got fr=%b want 1", flags_restore);
      end
      tick();
      reti = 1'b0;
      total++;
      if ({ie, stall} !== 2'b10) begin
         bad++; $display("FAIL prio_reti got ie=%b stall=%b want 1 0", ie, stall);
      end
      tick();
      total++;
      if ({push_pc, irq_id} !== {1'b1, 3'd3}) begin
         bad++; $display("FAIL prio_second got push=%b id=%0d want 1 3", push_pc, irq_id);
      end
      tick();
      total++;
      if ({load_vec, vector} !== {1'b1, 10'h3D8}) begin
         bad++; $display("FAIL prio_vec3 got load=%b vec=%h want 1 3d8", load_vec, vector);
      end
      tick();
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   task automatic test_mask();
      we_mask = 1'b1; mask_in = 4'b1110;
      tick();
      we_mask = 1'b0;
      irq = 4'b0001;
      tick();
      irq = 4'b0000;
      tick();
      tick();
      total++;
      if ({pending, stall} !== {4'b0001, 1'b0}) begin
         bad++; $display("FAIL mask_hold got pend=%b stall=%b want 0001 0", pending, stall);
      end
      we_mask = 1'b1; mask_in = 4'hF;
      tick();
      we_mask = 1'b0;
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL mask_write got stall=%b want 0", stall);
      end
      tick();
      total++;
      if ({push_pc, irq_id} !== {1'b1, 3'd0}) begin
         bad++; $display("FAIL mask_take got push=%b id=%0d want 1 0", push_pc, irq_id);
      end
      tick();
      total++;
      if ({load_vec, vector} !== {1'b1, 10'h3C0}) begin
         bad++; $display("FAIL mask_vec got load=%b vec=%h want 1 3c0", load_vec, vector);
      end
      tick();
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   task automatic test_flags();
      z_in = 1'b1; n_in = 1'b0;
      irq = 4'b0100;
      tick();
      irq = 4'b0000;
      tick();
      z_in = 1'b0; n_in = 1'b1;
      tick();
      tick();
      reti = 1'b1;
      #1;
      total++;
      if ({flags_restore, z_out, n_out, active} !== 4'b1101) begin
         bad++; $display("FAIL flags_restore got fr=%b z=%b n=%b act=%b want 1 1 0 1", flags_restore, z_out, n_out, active);
      end
      tick();
      reti = 1'b0;
      #1;
      total++;
      if ({ie, active, flags_restore} !== 3'b100) begin
         bad++; $display("FAIL flags_after got ie=%b act=%b fr=%b want 1 0 0", ie, active, flags_restore);
      end
   endtask

   task automatic test_ei_di();
      di = 1'b1;
      tick();
      di = 1'b0;
      irq = 4'b0001;
      tick();
      irq = 4'b0000;
      ei = 1'b1; di = 1'b1;
      tick();
      ei = 1'b0; di = 1'b0;
      total++;
      if ({ie, stall, pending} !== {2'b00, 4'b0001}) begin
         bad++; $display("FAIL eidi_same got ie=%b stall=%b pend=%b want 0 0 0001", ie, stall, pending);
      end
      tick();
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL eidi_notake got stall=%b want 0", stall);
      end
      ei = 1'b1;
      tick();
      ei = 1'b0;
      tick();
      total++;
      if (push_pc !== 1'b1) begin
         bad++; $display("FAIL eidi_take got push=%b want 1", push_pc);
      end
      di = 1'b1;
      tick();
      di = 1'b0;
      total++;
      if ({load_vec, vector} !== {1'b1, 10'h3C0}) begin
         bad++; $display("FAIL eidi_di_save got load=%b vec=%h want 1 3c0", load_vec, vector);
      end
      ei = 1'b1;
      tick();
      ei = 1'b0;
      total++;
      if ({ie, active, stall} !== 3'b010) begin
         bad++; $display("FAIL eidi_ei_jump got ie=%b act=%b stall=%b want 0 1 0", ie, active, stall);
      end
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   task automatic test_reset_mid();
      irq = 4'b0010;
      tick();
      irq = 4'b0000;
      tick();
      tick();
      total++;
      if (load_vec !== 1'b1) begin
         bad++; $display("FAIL rmid_jump got load=%b want 1", load_vec);
      end
      reset = 1'b1; irq = 4'b0001;
      tick();
      total++;
      if ({stall, push_pc, load_vec, flags_restore, ie, active, pending, irq_id, ret_pc, z_out, n_out} !== '0) begin
         bad++; $display("FAIL rmid_reset got stall=%b load=%b ie=%b act=%b pend=%b id=%0d ret=%h want all 0",
                         stall, load_vec, ie, active, pending, irq_id, ret_pc);
      end
      reset = 1'b0;
      tick();
      total++;
      if ({pending, stall} !== {4'b0001, 1'b0}) begin
         bad++; $display("FAIL rmid_held_edge got pend=%b stall=%b want 0001 0", pending, stall);
      end
      irq = 4'b0000;
   endtask

   task automatic test_random();
      logic [23:0] got, exp;
      logic        exp_fr;
      for (int c = 0; c < 600; c++) begin
         reset   = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 2) == 0) irq = irq ^ 4'($urandom);
         ei      = ($urandom_range(0, 5) == 0);
         di      = ($urandom_range(0, 9) == 0);
         reti    = ($urandom_range(0, 7) == 0);
         we_mask = ($urandom_range(0, 9) == 0);
         mask_in = 4'($urandom);
         pc_next = 10'($urandom);
         z_in    = 1'($urandom);
         n_in    = 1'($urandom);
         #1;
         exp_fr = (m_left == 0) && reti && (m_act != 0);
         total++;
         if (flags_restore !== exp_fr) begin
            bad++; $display("FAIL rand_fr cycle=%0d got %b want %b", c, flags_restore, exp_fr);
         end
         tick();
         got = {stall, push_pc, load_vec, ie, active, pending, irq_id, ret_pc, z_out, n_out};
         exp = {m_left > 0, m_left == 2, m_left == 1, m_ie != 0, m_act != 0,
                4'(m_pend), 3'(m_id), 10'(m_ret), m_z != 0, m_n != 0};
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL rand_state cycle=%0d got %h want %h", c, got, exp);
         end
         if (m_left == 1) begin
            total++;
            if (vector !== 10'((32'h3C0 + m_id * 8) % 1024)) begin
               bad++; $display("FAIL rand_vec cycle=%0d got %h id=%0d", c, vector, m_id);
            end
         end
      end
      reset = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0; we_mask = 1'b0; irq = '0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_mask();
      test_flags();
      test_ei_di();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised vectored interrupt controller for the single-cycle CPU; it generalises the CPU to N interrupt channels with masking, priority and flag save/restore. It sits beside the control unit. It latches edge-triggered requests and picks the highest-priority enabled channel at an instruction boundary. It then stalls the core for two cycles, pushes the return PC onto the hardware stack and loads the channel's vector into the PC. On `reti` it restores the saved Z/N flags.

## Interface
Parameters:
- N_IRQ, 4, number of request channels (1..8); channel 0 has the highest priority.
- PC_WIDTH, 10, program-counter width.
- VEC_BASE, 10'h3C0, vector of channel 0.
- VEC_STRIDE, 8, address distance between consecutive vectors.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- irq  in  N_IRQ  request lines, rising-edge sensitive.
- ei / di / reti  in  1 each  decoded-instruction strobes from control unit.
- we_mask  in  1  write enable for mask register.
- mask_in  in  N_IRQ  new mask (1 = enabled).
- pc_next  in  PC_WIDTH  address of the instruction after the current one.
- z_in, n_in  in  1  current flag values.
- stall  out  1  holds PC, register file and flags of the core.
- push_pc  out  1  stack push request; ret_pc is the data.
- ret_pc  out  PC_WIDTH  captured return address.
- load_vec  out  1  forces PC mux to vector.
- vector  out  PC_WIDTH  VEC_BASE + id*VEC_STRIDE (mod 2^PC_WIDTH).
- flags_restore  out  1  one-cycle pulse; core loads z_out/n_out into flags.
- z_out, n_out  out  1  saved flags.
- ie  out  1  global interrupt enable.
- active  out  1  an interrupt is in service.
- pending  out  N_IRQ  latched requests.
- irq_id  out  3  channel being or last serviced.

## Operation
- Edge detect: irq_q registers irq. pending[i] is set when irq[i] & ~irq_q[i]. pending[i] is cleared only when channel i is taken. If a new edge arrives in the same cycle as the clear, set wins.
- Mask: updated whenever we_mask=1, in any state. Masked requests stay pending and fire once unmasked.
- ie: set by ei or reti; cleared by di or by taking an interrupt. If ei and di arrive in the same cycle, di wins. In non-IDLE states, ei, di and reti are ignored.
- Take condition (IDLE only): ie & ~di & |(pending & mask). The winner is the lowest eligible index.
- FSM IDLE -> SAVE -> JUMP -> IDLE.
  - IDLE→SAVE (on take): capture ret_pc<=pc_next, irq_id<=winner, z_out/n_out<=z_in/n_in; clear pending[winner]; ie<=0; active<=1.
  - SAVE: stall=1, push_pc=1.
  - JUMP: stall=1, load_vec=1, vector from irq_id.
- reti in IDLE:
  - With active=1: active<=0, ie<=1, flags_restore=1 for that cycle.
  - With active=0: ie<=1 only, no restore.
- No nesting: ie stays 0 while in service unless software executes ei.
- vector: combinational from irq_id; only meaningful while load_vec=1.

## Timing
- Reset (synchronous) outputs: state IDLE; pending, mask, ie, active, irq_q, ret_pc, irq_id, z_out, n_out all 0; stall, push_pc, load_vec, flags_restore all 0.
- Because irq_q resets to 0, an irq line held high at reset release registers one edge on the first clock after reset.
- Reset mid-entry (SAVE or JUMP) aborts the entry; the request is lost.
- Latency from an irq rising edge sampled at clock k:
  - pending=1 after k.
  - SAVE after k+1 (if ie and mask allow).
  - JUMP after k+2.
  - The core fetches from vector after k+3.
- Minimum 3 cycles edge-to-vector; stall is high for exactly 2 cycles.
- The instruction executing in the IDLE cycle of the take completes normally; ret_pc is its successor.
- flags_restore and the ie update take effect at the same clock edge as the reti instruction.

## Test plan
- Reset, mask=4'b1111, ei. Pulse irq[2] with pc_next=10'h020 -> pending=4'b0100, SAVE (push_pc=1, ret_pc=10'h020), JUMP (load_vec=1, vector=10'h3D0), then active=1, ie=0, pending=0.
- Raise irq[3] and irq[1] in the same cycle with ie=1 -> channel 1 taken (vector 10'h3C8); pending=4'b1000 remains. After reti, channel 3 is taken 1 cycle later (vector 10'h3D8).
- mask=4'b1110, pulse irq[0] -> pending[0]=1, no stall. Write mask=4'b1111 -> entry starts the next cycle with vector 10'h3C0.
- Enter with z_in=1, n_in=0. In the ISR, drive z_in=0, n_in=1, then reti -> flags_restore=1 with z_out=1, n_out=0; ie=1, active=0.
- ei and di in the same cycle with an eligible pending request -> ie=0, no take. di during SAVE is ignored; the entry completes.
- Assert reset during JUMP -> next cycle all outputs 0 and state IDLE. Hold irq[0] high across reset release -> pending[0]=1 after the first clock.
